// File: rtl/wb_write_queue_pkg.sv
// Shared sizing defaults for the write-back queue and its forwarding search.
// Pointer width is derived from DEPTH; count carries one extra bit for "full".
package wb_write_queue_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Pipeline-side bundle of the write-back queue: result inputs, stall, register-file
// write port, two decode forwarding ports and status.
interface wb_write_queue_if
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int REG_W = REG_W_DEF
);

  localparam int CNT_W = ptr_w(DEPTH) + 1;

  logic             ld_valid;
  logic [REG_W-1:0] ld_rd;
  logic [XLEN-1:0]  ld_data;
  logic             alu_valid;
  logic [REG_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             stall;

  logic             regwrite;
  logic [REG_W-1:0] write_reg;
  logic [XLEN-1:0]  write_data;

  logic [REG_W-1:0] fwd_reg_1;
  logic [REG_W-1:0] fwd_reg_2;
  logic             fwd_hit_1;
  logic             fwd_hit_2;
  logic [XLEN-1:0]  fwd_data_1;
  logic [XLEN-1:0]  fwd_data_2;

  logic [CNT_W-1:0] count;
  logic             overflow_err;

  // master = pipeline feeding the queue, slave = the queue itself
  modport master (
    output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    output fwd_reg_1, fwd_reg_2,
    input  stall, regwrite, write_reg, write_data,
    input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
    input  count, overflow_err
  );

  modport slave (
    input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
    input  fwd_reg_1, fwd_reg_2,
    output stall, regwrite, write_reg, write_data,
    output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
    output count, overflow_err
  );

endinterface

// File: rtl/wb_fwd_match.sv
// Combinational youngest-match search over the output stage and queued entries.
// Zero latency; no backpressure -- a pure lookup.
module wb_fwd_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic [DEPTH-1:0]            ent_vld,
  input  logic [DEPTH-1:0][REG_W-1:0] ent_rd,
  input  logic [DEPTH-1:0][XLEN-1:0]  ent_data,
  input  logic [ptr_w(DEPTH)-1:0]     head,
  input  logic                        out_vld,
  input  logic [REG_W-1:0]            out_rd,
  input  logic [XLEN-1:0]             out_data,
  input  logic [REG_W-1:0]            fwd_reg,
  output logic                        fwd_hit,
  output logic [XLEN-1:0]             fwd_data
);

  localparam int PTR_W = ptr_w(DEPTH);

  // Walk oldest-to-youngest starting at head so later matches overwrite earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    if (out_vld && (out_rd == fwd_reg)) begin
      fwd_hit  = 1'b1;
      fwd_data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_vld[idx] && (ent_rd[idx] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue merging load and ALU results into one register-file write per cycle;
// one-cycle queue-to-port latency, stalls upstream below two free slots and drops on overflow.
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_queue_if.slave   bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]  ent_data;
  logic [PTR_W-1:0]            head;
  logic [PTR_W-1:0]            tail;
  logic [CNT_W-1:0]            cnt;

  logic                        regwrite_q;
  logic [REG_W-1:0]            write_reg_q;
  logic [XLEN-1:0]             write_data_q;
  logic                        overflow_q;

  logic                        stall_w;
  logic                        pop;
  logic                        drop;
  logic [1:0]                  n_in;
  logic                        we0;
  logic                        we1;
  logic [REG_W-1:0]            rd0;
  logic [REG_W-1:0]            rd1;
  logic [XLEN-1:0]             dat0;
  logic [XLEN-1:0]             dat1;
  logic [PTR_W-1:0]            tail_p1;

  logic                        hit_1;
  logic                        hit_2;
  logic [XLEN-1:0]             data_1;
  logic [XLEN-1:0]             data_2;

  assign stall_w = (cnt >= CNT_W'(DEPTH - 1));
  assign pop     = (cnt != '0);
  assign drop    = stall_w && (bus.ld_valid || bus.alu_valid);
  assign tail_p1 = tail + PTR_W'(1);

  // The load is the older instruction, so it takes the first free slot.
  always_comb begin
    we0  = 1'b0;
    we1  = 1'b0;
    rd0  = '0;
    rd1  = '0;
    dat0 = '0;
    dat1 = '0;
    n_in = 2'd0;
    if (!stall_w) begin
      if (bus.ld_valid) begin
        we0  = 1'b1;
        rd0  = bus.ld_rd;
        dat0 = bus.ld_data;
        n_in = 2'd1;
        if (bus.alu_valid) begin
          we1  = 1'b1;
          rd1  = bus.alu_rd;
          dat1 = bus.alu_data;
          n_in = 2'd2;
        end
      end else if (bus.alu_valid) begin
        we0  = 1'b1;
        rd0  = bus.alu_rd;
        dat0 = bus.alu_data;
        n_in = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      ent_vld      <= '0;
      ent_rd       <= '0;
      ent_data     <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (pop) begin
        regwrite_q    <= 1'b1;
        write_reg_q   <= ent_rd[head];
        write_data_q  <= ent_data[head];
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end else begin
        regwrite_q <= 1'b0;
      end
      // Enqueue slots never collide with head: stall guarantees two free slots.
      if (we0) begin
        ent_vld[tail]  <= 1'b1;
        ent_rd[tail]   <= rd0;
        ent_data[tail] <= dat0;
      end
      if (we1) begin
        ent_vld[tail_p1]  <= 1'b1;
        ent_rd[tail_p1]   <= rd1;
        ent_data[tail_p1] <= dat1;
      end
      tail <= tail + PTR_W'(n_in);
      cnt  <= cnt + CNT_W'(n_in) - CNT_W'(pop);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) u_fwd_1 (
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .head     (head),
    .out_vld  (regwrite_q),
    .out_rd   (write_reg_q),
    .out_data (write_data_q),
    .fwd_reg  (bus.fwd_reg_1),
    .fwd_hit  (hit_1),
    .fwd_data (data_1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) u_fwd_2 (
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd),
    .ent_data (ent_data),
    .head     (head),
    .out_vld  (regwrite_q),
    .out_rd   (write_reg_q),
    .out_data (write_data_q),
    .fwd_reg  (bus.fwd_reg_2),
    .fwd_hit  (hit_2),
    .fwd_data (data_2)
  );

  assign bus.stall        = stall_w;
  assign bus.regwrite     = regwrite_q;
  assign bus.write_reg    = write_reg_q;
  assign bus.write_data   = write_data_q;
  assign bus.fwd_hit_1    = hit_1;
  assign bus.fwd_hit_2    = hit_2;
  assign bus.fwd_data_1   = data_1;
  assign bus.fwd_data_2   = data_2;
  assign bus.count        = cnt;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: drain latency, ordering, forwarding priority,
// stall/overflow, asynchronous reset and a throttled two-per-cycle stream.
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  wb_write_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
  endtask

  task automatic drive(input logic lv, input logic [REG_W-1:0] lr, input logic [XLEN-1:0] ldat,
                       input logic av, input logic [REG_W-1:0] ar, input logic [XLEN-1:0] adat);
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ldat;
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = adat;
  endtask

  logic [REG_W-1:0] exp_rd[$];
  logic [XLEN-1:0]  exp_dat[$];
  int               model_cnt;
  int               pre;
  int               n_acc;
  int               n_wr;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b0;
    idle();
    bus.fwd_reg_1 = '0;
    bus.fwd_reg_2 = '0;
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_regwrite", bus.regwrite, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_overflow", bus.overflow_err, 0);
    chk("rst_stall", bus.stall, 0);
    step();
    rst = 1'b1;

    // Single ALU result, also visible to forwarding while queued and in output stage
    bus.fwd_reg_1 = 5'd5;
    drive(0, 0, 0, 1, 5'd5, 32'h1E);
    step();
    idle();
    chk("t1_count_q", bus.count, 1);
    chk("t1_rw_q", bus.regwrite, 0);
    chk("t1_fwd_q_hit", bus.fwd_hit_1, 1);
    chk("t1_fwd_q_data", bus.fwd_data_1, 32'h1E);
    step();
    chk("t1_rw", bus.regwrite, 1);
    chk("t1_reg", bus.write_reg, 5);
    chk("t1_data", bus.write_data, 32'h1E);
    chk("t1_count", bus.count, 0);
    chk("t1_fwd_out_hit", bus.fwd_hit_1, 1);
    step();
    chk("t1_rw_off", bus.regwrite, 0);
    chk("t1_reg_hold", bus.write_reg, 5);
    chk("t1_data_hold", bus.write_data, 32'h1E);
    chk("t1_fwd_off", bus.fwd_hit_1, 0);

    // Load and ALU together: load written first; same-cycle inputs are not forwarded
    bus.fwd_reg_1 = 5'd3;
    drive(1, 5'd3, 32'h4, 1, 5'd7, 32'h6);
    #1;
    chk("t2_fwd_same_cycle", bus.fwd_hit_1, 0);
    step();
    idle();
    chk("t2_count", bus.count, 2);
    step();
    chk("t2_rw0", bus.regwrite, 1);
    chk("t2_reg0", bus.write_reg, 3);
    chk("t2_data0", bus.write_data, 32'h4);
    chk("t2_count1", bus.count, 1);
    step();
    chk("t2_rw1", bus.regwrite, 1);
    chk("t2_reg1", bus.write_reg, 7);
    chk("t2_data1", bus.write_data, 32'h6);
    step();
    chk("t2_rw_off", bus.regwrite, 0);

    // Two pending writes to x9: youngest value wins everywhere
    bus.fwd_reg_1 = 5'd9;
    bus.fwd_reg_2 = 5'd12;
    drive(1, 5'd9, 32'h7, 1, 5'd9, 32'hA);
    step();
    idle();
    chk("t3_qq_hit", bus.fwd_hit_1, 1);
    chk("t3_qq_data", bus.fwd_data_1, 32'hA);
    chk("t3_miss_hit", bus.fwd_hit_2, 0);
    chk("t3_miss_data", bus.fwd_data_2, 0);
    step();
    chk("t3_out_old", bus.write_data, 32'h7);
    chk("t3_qo_data", bus.fwd_data_1, 32'hA);
    step();
    chk("t3_o_hit", bus.fwd_hit_1, 1);
    chk("t3_o_data", bus.fwd_data_1, 32'hA);
    step();
    chk("t3_none_hit", bus.fwd_hit_1, 0);
    chk("t3_none_data", bus.fwd_data_1, 0);

    // Fill to three entries, then inputs are dropped and overflow sticks
    drive(1, 5'd10, 32'h100, 1, 5'd11, 32'h101);
    step();
    chk("t4_count2", bus.count, 2);
    chk("t4_stall2", bus.stall, 0);
    drive(1, 5'd12, 32'h102, 1, 5'd13, 32'h103);
    step();
    chk("t4_count3", bus.count, 3);
    chk("t4_stall3", bus.stall, 1);
    chk("t4_w10", bus.write_reg, 10);
    drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
    step();
    idle();
    chk("t4_count_drop", bus.count, 2);
    chk("t4_overflow", bus.overflow_err, 1);
    chk("t4_w11", bus.write_reg, 11);
    step();
    chk("t4_w12", bus.write_reg, 12);
    step();
    chk("t4_w13", bus.write_reg, 13);
    chk("t4_d13", bus.write_data, 32'h103);
    chk("t4_count0", bus.count, 0);
    step();
    chk("t4_rw_off", bus.regwrite, 0);
    chk("t4_overflow_hold", bus.overflow_err, 1);

    // Asynchronous reset with three entries pending
    drive(1, 5'd20, 32'h200, 1, 5'd21, 32'h201);
    step();
    drive(1, 5'd22, 32'h202, 1, 5'd23, 32'h203);
    step();
    idle();
    chk("t5_pre_count", bus.count, 3);
    rst = 1'b0;
    #1;
    chk("t5_count", bus.count, 0);
    chk("t5_rw", bus.regwrite, 0);
    chk("t5_reg", bus.write_reg, 0);
    chk("t5_overflow", bus.overflow_err, 0);
    chk("t5_stall", bus.stall, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_write", bus.regwrite, 0);
      chk("t5_count_post", bus.count, 0);
    end

    // Continuous two-per-cycle stream throttled by stall, then drain
    model_cnt = 0;
    n_acc     = 0;
    n_wr      = 0;
    for (int k = 0; k < 18; k++) begin
      chk("t6_stall", bus.stall, (model_cnt >= DEPTH - 1) ? 1 : 0);
      if (k < 12) begin
        drive(1, REG_W'(k), 32'h2000 + k, 1, REG_W'(k + 16), 32'h3000 + k);
      end else begin
        idle();
      end
      pre = model_cnt;
      if (k < 12 && model_cnt < DEPTH - 1) begin
        exp_rd.push_back(REG_W'(k));
        exp_dat.push_back(32'h2000 + k);
        exp_rd.push_back(REG_W'(k + 16));
        exp_dat.push_back(32'h3000 + k);
        n_acc     += 2;
        model_cnt += 2;
      end
      if (pre > 0) model_cnt -= 1;
      step();
      chk("t6_rw", bus.regwrite, (pre > 0) ? 1 : 0);
      if (pre > 0 && exp_rd.size() > 0) begin
        n_wr++;
        chk("t6_reg", bus.write_reg, exp_rd.pop_front());
        chk("t6_data", bus.write_data, exp_dat.pop_front());
      end
      chk("t6_count", bus.count, model_cnt);
    end
    idle();
    chk("t6_all_written", n_wr, n_acc);
    chk("t6_left", exp_rd.size(), 0);
    chk("t6_overflow", bus.overflow_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write-back entries (power of two, >= 4).
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter REG_W, default 5, register-index width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 ld_valid  input  1  load result present this cycle.
REQ-008 ld_rd  input  REG_W  load destination index.
REQ-009 ld_data  input  XLEN  load result.
REQ-010 alu_valid  input  1  ALU result present this cycle.
REQ-011 alu_rd  input  REG_W  ALU destination index.
REQ-012 alu_data  input  XLEN  ALU result.
REQ-013 stall  output  1  fewer than two free slots; upstream holds inputs.
REQ-014 regwrite  output  1  register-file write enable, registered.
REQ-015 write_reg  output  REG_W  register-file write index, registered.
REQ-016 write_data  output  XLEN  register-file write data, registered.
REQ-017 fwd_reg_1 / fwd_reg_2  input  REG_W  indices being read by decode.
REQ-018 fwd_hit_1 / fwd_hit_2  output  1  pending write to that index exists.
REQ-019 fwd_data_1 / fwd_data_2  output  XLEN  youngest pending value for that index.
REQ-020 count  output  log2(DEPTH)+1  queued entries, excluding output stage.
REQ-021 overflow_err  output  1  sticky, set when an input is dropped.

Function
REQ-022 Circular FIFO with head/tail pointers wrapping modulo DEPTH; count tracks occupancy.
REQ-023 stall = (count >= DEPTH-1), combinational from current count.
REQ-024 When stall=0: ld entry enqueued before alu entry (load older) when both valid; one entry enqueued when only one is valid.
REQ-025 When stall=1: valid inputs dropped, queue unchanged by them, overflow_err set to 1 next edge and held until reset.
REQ-026 Drain: at each edge, if count>0 (pre-edge), head pops into output stage, regwrite=1 next cycle; else regwrite=0 and write_reg/write_data hold last values.
REQ-027 Latency: entry enqueued at edge k into empty queue appears on write port after edge k+1; one write per cycle max.
REQ-028 Simultaneous enqueue and drain: count_next = count + n_in - pop, n_in in {0,1,2}, pop in {0,1}.
REQ-029 Register indices pass unchanged; index 0 receives no special treatment.
REQ-030 Forwarding search covers output stage (when regwrite=1) and all valid queued entries; same-cycle inputs excluded.
REQ-031 Multiple matches: youngest entry wins (newest queued > older queued > output stage).
REQ-032 No match: fwd_hit=0, fwd_data=0; forwarding is purely combinational.

Reset
REQ-033 rst=0 asynchronously forces: pointers 0, count 0, all entry valids 0, regwrite 0, write_reg 0, write_data 0, overflow_err 0, stall 0.
REQ-034 Reset mid-operation discards all pending entries; no write issued on reset release edge.

Structure
REQ-035 Shared package holds XLEN, REG_W, DEPTH defaults and pointer-width constant.
REQ-036 Sub-module wb_fwd_match (combinational youngest-match search) instantiated once per read port.

Verification
REQ-037 Empty queue, ALU x5=0x1E at edge 0 -> regwrite=1, write_reg=5, write_data=0x1E after edge 1; count back to 0.
REQ-038 Same cycle ld x3=0x4, alu x7=0x6 -> writes x3 then x7 on consecutive cycles.
REQ-039 Queue x9=0x7 then x9=0xA pending, fwd_reg_1=9 -> fwd_hit_1=1, fwd_data_1=0xA; fwd_reg_2=12 -> hit 0, data 0.
REQ-040 Fill to count=3 (DEPTH 4) -> stall=1; inputs applied -> dropped, overflow_err=1, count unchanged.
REQ-041 rst low with 3 entries pending -> count=0, regwrite=0 immediately; after release no spurious write.
REQ-042 Continuous two-per-cycle input -> stall throttles, every accepted entry written exactly once in order.
